// File: rtl/lfsr_generator_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator: word width, FSM states and the
// next-state polynomial (Galois taps on bits 2,3,4 with zero-state insertion, period 256).
package lfsr_generator_pkg;

    localparam int unsigned LfsrW = 8;

    typedef enum logic {
        StIdle,
        StRun
    } gen_state_e;

    // 0x80 steps to 0x00 and 0x00 steps to 0x1D, so the all-zero word sits inside the cycle.
    function automatic logic [LfsrW-1:0] lfsr8_next(input logic [LfsrW-1:0] s);
        logic fb;
        fb = s[7] ^ (s[6:0] == 7'd0);
        return {s[6], s[5], s[4], s[3] ^ fb, s[2] ^ fb, s[1] ^ fb, s[0], fb};
    endfunction

endpackage

// File: rtl/lfsr8_step.sv
// Combinational single-step of the shared 8-bit LFSR; the generator and checker both instantiate
// this so the two sides cannot drift onto different polynomials.
module lfsr8_step
    import lfsr_generator_pkg::*;
(
    input  logic [LfsrW-1:0] state_i,
    output logic [LfsrW-1:0] next_o
);

    assign next_o = lfsr8_next(state_i);

endmodule

// File: rtl/lfsr_generator.sv
// LFSR pattern source: emits one registered 8-bit word per beat in continuous or burst mode,
// with a loadable seed and one-shot error injection for link testing.
module lfsr_generator
    import lfsr_generator_pkg::*;
#(
    parameter logic [LfsrW-1:0] SEED_DEFAULT = 8'hFF,
    parameter int unsigned      BLEN_W       = 8
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_seed_load,
    input  logic [LfsrW-1:0]  i_seed,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [BLEN_W-1:0] i_burst_len,
    input  logic              i_hold,
    input  logic              i_err_inject,
    input  logic [LfsrW-1:0]  i_err_mask,
    output logic [LfsrW-1:0]  o_lfsr,
    output logic              o_valid,
    output logic [LfsrW-1:0]  o_seed_reg,
    output logic              o_busy,
    output logic [7:0]        o_err_count
);

    gen_state_e        state_q;
    logic [BLEN_W-1:0] blen_q;
    logic [BLEN_W-1:0] beat_cnt_q;
    logic [BLEN_W-1:0] beat_cnt_inc;
    logic [LfsrW-1:0]  lfsr_q;
    logic [LfsrW-1:0]  lfsr_nx;
    logic [LfsrW-1:0]  seed_q;
    logic [LfsrW-1:0]  mask_q;
    logic              err_pending_q;
    logic              beat;
    logic              burst_done;

    lfsr8_step u_step (
        .state_i (lfsr_q),
        .next_o  (lfsr_nx)
    );

    // A seed load in the same cycle pre-empts any beat.
    assign beat         = (state_q == StRun) && !i_hold && !i_seed_load;
    assign beat_cnt_inc = beat_cnt_q + BLEN_W'(1);
    assign burst_done   = beat && (blen_q != '0) && (beat_cnt_inc == blen_q);

    assign o_seed_reg = seed_q;
    assign o_busy     = (state_q == StRun);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            blen_q  <= '0;
        end else if (i_seed_load) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q <= StRun;
                        blen_q  <= i_burst_len;
                    end
                end
                StRun: begin
                    if (i_stop || burst_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q  <= SEED_DEFAULT;
            seed_q  <= SEED_DEFAULT;
            o_lfsr  <= '0;
            o_valid <= 1'b0;
        end else if (i_seed_load) begin
            lfsr_q  <= i_seed;
            seed_q  <= i_seed;
            o_valid <= 1'b0;
        end else if (beat) begin
            o_lfsr  <= lfsr_q ^ (err_pending_q ? mask_q : '0);
            o_valid <= 1'b1;
            lfsr_q  <= lfsr_nx;
        end else begin
            o_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_q    <= '0;
            err_pending_q <= 1'b0;
            mask_q        <= '0;
            o_err_count   <= '0;
        end else begin
            if (i_seed_load || (state_q == StIdle && i_start)) begin
                beat_cnt_q <= '0;
            end else if (beat) begin
                beat_cnt_q <= beat_cnt_inc;
            end
            // A fresh inject wins over the clear so it lands on the following beat.
            if (i_err_inject) begin
                err_pending_q <= 1'b1;
                mask_q        <= i_err_mask;
            end else if (beat) begin
                err_pending_q <= 1'b0;
            end
            if (beat && err_pending_q && (o_err_count != 8'hFF)) begin
                o_err_count <= o_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_generator.sv
// Self-checking bench for lfsr_generator: scoreboard of expected words built from an independent
// reference step, compared against every valid output beat.
module tb_lfsr_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed;
    logic       start;
    logic       stop;
    logic [7:0] burst_len;
    logic       hold;
    logic       err_inject;
    logic [7:0] err_mask;
    logic [7:0] o_lfsr;
    logic       o_valid;
    logic [7:0] o_seed_reg;
    logic       o_busy;
    logic [7:0] o_err_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    logic [7:0] m_lfsr;

    lfsr_generator dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .i_start      (start),
        .i_stop       (stop),
        .i_burst_len  (burst_len),
        .i_hold       (hold),
        .i_err_inject (err_inject),
        .i_err_mask   (err_mask),
        .o_lfsr       (o_lfsr),
        .o_valid      (o_valid),
        .o_seed_reg   (o_seed_reg),
        .o_busy       (o_busy),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Shift-and-xor form of the polynomial, with the two zero-insertion states special-cased.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        if (s == 8'h80) return 8'h00;
        if (s == 8'h00) return 8'h1D;
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seed_load = 0; seed = 0; start = 0; stop = 0; burst_len = 0;
        hold = 0; err_inject = 0; err_mask = 0;
        repeat (2) step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_seed_reg !== 8'hFF) begin errors++; $display("FAIL reset_seed: got %h want ff", o_seed_reg); end
        checks++; if (o_err_count !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %h want 00", o_err_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_lfsr !== 8'h00) begin errors++; $display("FAIL reset_lfsr: got %h want 00", o_lfsr); end
        rst_n = 1'b1;
        step();
        m_lfsr = 8'hFF;
    endtask

    task automatic test_burst();
        logic [7:0] tab [10];
        int n;
        tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D};
        seed = 8'h01; seed_load = 1; step(); seed_load = 0;
        m_lfsr = 8'h01;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(tab[i]);
            m_lfsr = ref_next(m_lfsr);
        end
        burst_len = 8'd10; start = 1; step(); start = 0;
        burst_len = 8'd3;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b want 1", o_busy); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL burst_latency1: got %b want 0", o_valid); end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 0) begin
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL burst_latency2: got %b want 1", o_valid); end
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL burst_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL burst_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
            end
            if (n == 10) break;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL burst_count: got %0d want 10", n); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy: got %b want 0", o_busy); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL burst_after_valid: got %b want 0", o_valid); end
        exp_q.delete();
    endtask

    task automatic test_continuous();
        logic seen [256];
        int n;
        int distinct;
        logic [7:0] last;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seed = 8'hA5; seed_load = 1; step(); seed_load = 0;
        m_lfsr = 8'hA5;
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back(m_lfsr);
            m_lfsr = ref_next(m_lfsr);
        end
        burst_len = 8'd0; start = 1; step(); start = 0;
        n = 0; distinct = 0; last = 8'h00;
        for (int c = 0; c < 400; c++) begin
            step();
            stop = 0;
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL cont_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL cont_word: got %h want %h", o_lfsr, exp_w); end
                end
                if (n < 256 && !seen[o_lfsr]) begin seen[o_lfsr] = 1'b1; distinct++; end
                last = o_lfsr;
                n++;
                if (n == 256) stop = 1;
            end
            if (n == 257) break;
        end
        stop = 0;
        checks++; if (n != 257) begin errors++; $display("FAIL cont_count: got %0d want 257", n); end
        checks++; if (last !== 8'hA5) begin errors++; $display("FAIL cont_wrap: got %h want a5", last); end
        checks++; if (distinct != 256) begin errors++; $display("FAIL cont_distinct: got %0d want 256", distinct); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy: got %b want 0", o_busy); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL cont_stop_valid: got %b want 0", o_valid); end
        exp_q.delete();
    endtask

    // Resumes from where the continuous run stopped, so this also checks stop/restart continuity.
    task automatic test_hold();
        int n;
        burst_len = 8'd0; start = 1; step(); start = 0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            hold = (k % 2) == 1;
            if (!hold) begin
                exp_q.push_back(m_lfsr);
                m_lfsr = ref_next(m_lfsr);
            end
            step();
            checks++; if (o_valid !== !hold) begin errors++; $display("FAIL hold_valid: got %b want %b", o_valid, !hold); end
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL hold_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL hold_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
            end
        end
        hold = 1; stop = 1; step(); stop = 0; hold = 0;
        checks++; if (n != 10) begin errors++; $display("FAIL hold_count: got %0d want 10", n); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL hold_stop_busy: got %b want 0", o_busy); end
        exp_q.delete();
    endtask

    task automatic test_inject();
        int n;
        seed = 8'h01; seed_load = 1; step(); seed_load = 0;
        m_lfsr = 8'h01;
        err_inject = 1; err_mask = 8'h01; step(); err_inject = 0; err_mask = 8'h00;
        step(); step();
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL inj_pending_cnt: got %h want 00", o_err_count); end
        for (int j = 0; j < 6; j++) begin
            exp_w = m_lfsr;
            if (j == 0) exp_w = exp_w ^ 8'h01;
            if (j == 4) exp_w = exp_w ^ 8'h80;
            exp_q.push_back(exp_w);
            m_lfsr = ref_next(m_lfsr);
        end
        burst_len = 8'd6; start = 1; step(); start = 0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            err_inject = (c == 3);
            err_mask = (c == 3) ? 8'h80 : 8'h00;
            step();
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL inj_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL inj_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
            end
        end
        err_inject = 0; err_mask = 0;
        checks++; if (n != 6) begin errors++; $display("FAIL inj_count: got %0d want 6", n); end
        checks++; if (o_err_count !== 8'd2) begin errors++; $display("FAIL inj_errcnt: got %h want 02", o_err_count); end

        // Second inject while pending replaces the mask and is counted once.
        err_inject = 1; err_mask = 8'h10; step();
        err_mask = 8'h40; step();
        err_inject = 0; err_mask = 0;
        exp_q.push_back(m_lfsr ^ 8'h40);
        m_lfsr = ref_next(m_lfsr);
        burst_len = 8'd1; start = 1; step(); start = 0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL inj_ovr_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL inj_ovr_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
            end
        end
        checks++; if (n != 1) begin errors++; $display("FAIL inj_ovr_count: got %0d want 1", n); end
        checks++; if (o_err_count !== 8'd3) begin errors++; $display("FAIL inj_ovr_errcnt: got %h want 03", o_err_count); end

        // Zero-mask injects on every beat: words unchanged, counter must saturate.
        for (int i = 0; i < 260; i++) begin
            exp_q.push_back(m_lfsr);
            m_lfsr = ref_next(m_lfsr);
        end
        err_inject = 1; err_mask = 8'h00;
        burst_len = 8'd0; start = 1; step(); start = 0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            stop = 0;
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL inj_sat_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL inj_sat_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
                if (n == 259) stop = 1;
            end
            if (n == 260) break;
        end
        stop = 0; err_inject = 0;
        checks++; if (n != 260) begin errors++; $display("FAIL inj_sat_count: got %0d want 260", n); end
        checks++; if (o_err_count !== 8'hFF) begin errors++; $display("FAIL inj_sat_errcnt: got %h want ff", o_err_count); end
        exp_q.delete();
    endtask

    task automatic test_seed_start();
        int n;
        seed = 8'h3C; seed_load = 1; start = 1; step(); seed_load = 0; start = 0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ss_busy: got %b want 0", o_busy); end
        checks++; if (o_seed_reg !== 8'h3C) begin errors++; $display("FAIL ss_seed: got %h want 3c", o_seed_reg); end
        step();
        checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++; $display("FAIL ss_idle: got busy=%b valid=%b want 0/0", o_busy, o_valid);
        end
        m_lfsr = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(m_lfsr);
            m_lfsr = ref_next(m_lfsr);
        end
        burst_len = 8'd0; start = 1; step(); start = 0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL ss_word: got %h want none", o_lfsr); end
                else begin
                    exp_w = exp_q.pop_front();
                    if (o_lfsr !== exp_w) begin errors++; $display("FAIL ss_word: got %h want %h", o_lfsr, exp_w); end
                end
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL ss_count: got %0d want 3", n); end
        seed = 8'h5A; seed_load = 1; step(); seed_load = 0;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL ss_midload: got busy=%b valid=%b want 0/0", o_busy, o_valid);
        end
        checks++; if (o_seed_reg !== 8'h5A) begin errors++; $display("FAIL ss_midseed: got %h want 5a", o_seed_reg); end
        burst_len = 8'd1; start = 1; step(); start = 0;
        step();
        checks++; if (o_valid !== 1'b1 || o_lfsr !== 8'h5A) begin
            errors++; $display("FAIL ss_firstword: got valid=%b word=%h want 1/5a", o_valid, o_lfsr);
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        burst_len = 8'd0; start = 1; step(); start = 0;
        repeat (3) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL areset_ctl: got busy=%b valid=%b want 0/0", o_busy, o_valid);
        end
        checks++; if (o_lfsr !== 8'h00 || o_err_count !== 8'h00) begin
            errors++; $display("FAIL areset_data: got lfsr=%h cnt=%h want 00/00", o_lfsr, o_err_count);
        end
        checks++; if (o_seed_reg !== 8'hFF) begin errors++; $display("FAIL areset_seed: got %h want ff", o_seed_reg); end
        #2;
        rst_n = 1'b1;
        step();
        burst_len = 8'd2; start = 1; step(); start = 0;
        step();
        checks++; if (o_valid !== 1'b1 || o_lfsr !== 8'hFF) begin
            errors++; $display("FAIL areset_w0: got valid=%b word=%h want 1/ff", o_valid, o_lfsr);
        end
        step();
        checks++; if (o_valid !== 1'b1 || o_lfsr !== ref_next(8'hFF)) begin
            errors++; $display("FAIL areset_w1: got valid=%b word=%h want 1/%h", o_valid, o_lfsr, ref_next(8'hFF));
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL areset_end_busy: got %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_hold();
        test_inject();
        test_seed_start();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
